// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
//   Word-organised backing store serving the data cache's miss traffic
//   (write-backs and line fills). The array is read every cycle into a
//   fixed-latency pipeline. The initiator counts cycles, so there is no
//   handshake. A stability counter qualifies the output. A sticky flag
//   records any access whose address lies above the implemented range.
//
// Parameters
//   ADDR_WIDTH    word-address bits implemented (capacity 2^ADDR_WIDTH words)
//   READ_LATENCY  cycles from address capture to data on mem_data_out (1..6)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous, active-high; the array contents survive it
//   mem_addr      byte address; [1:0] ignored, word index = [ADDR_WIDTH+1:2]
//   data_in       write data, lane 0 = MSB byte ... lane 3 = LSB byte
//   mem_write_en  write strobe, one word per cycle while high
//   mem_data_out  read data, same lane order as data_in
//   data_valid    mem_data_out corresponds to the current mem_addr
//   addr_error    sticky, set by any access with address bits above
//                 ADDR_WIDTH+1
//
// Build option
//   MEM_WRITE_BYPASS_EN  when defined, a write forwards data_in into every
//                        in-flight pipeline stage that captured the same word,
//                        and the write no longer restarts the stable counter.
// -----------------------------------------------------------------------------
module main_memory #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] data_in,
  input  logic            mem_write_en,
  output logic [0:3][7:0] mem_data_out,
  output logic            data_valid,
  output logic            addr_error
);

  localparam int         DEPTH           = 1 << ADDR_WIDTH;
  localparam logic [2:0] VALID_THRESHOLD = 3'(READ_LATENCY);
  localparam logic [2:0] CNT_MAX         = 3'd7;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  wr;
  logic [31:0]           rd_word;
  logic [31:0]           mem        [DEPTH];
  logic [31:0]           stage_data [READ_LATENCY];
  logic [31:0]           stage_next [READ_LATENCY];
  logic [29:0]           prev_word;
  logic [2:0]            stable_cnt;
  logic [2:0]            cnt_next;
  logic                  addr_changed;
  logic                  write_breaks;
  logic                  unused_byte_offset;

  // Direct slice, no modulo aliasing: upper bits only feed the range check.
  assign word_idx           = mem_addr[ADDR_WIDTH+1:2];
  assign in_range           = (mem_addr[31:ADDR_WIDTH+2] == '0);
  assign wr                 = mem_write_en & in_range & ~reset;
  assign unused_byte_offset = ^mem_addr[1:0];

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch on purpose; clearing a RAM needs a
  // per-word sequencer and would stop the tools from mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[word_idx] <= data_in;
    end
  end

  // Combinational read of the current word. The write above is non-blocking,
  // so a same-edge write to this word is not yet visible (read-before-write).
  assign rd_word = in_range ? mem[word_idx] : '0;

  // ---------------------------------------------------------------------------
  // Optional write forwarding into the read pipeline
  // ---------------------------------------------------------------------------
`ifdef MEM_WRITE_BYPASS_EN
  logic [ADDR_WIDTH-1:0] stage_idx  [READ_LATENCY];
  logic                  stage_live [READ_LATENCY];

  // Word index captured alongside each stage. Out-of-range samples are never
  // live, so a write can never forward into them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_idx[i]  <= '0;
        stage_live[i] <= 1'b0;
      end
    end else begin
      stage_idx[0]  <= word_idx;
      stage_live[0] <= in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_idx[i]  <= stage_idx[i-1];
        stage_live[i] <= stage_live[i-1];
      end
    end
  end

  // Forwarding keeps in-flight data current, so a write does not disturb it.
  assign write_breaks = 1'b0;
`else
  assign write_breaks = mem_write_en;
`endif

  // NOTE: every stage_next entry is given a value before any condition is
  // tested; a path that leaves one unassigned would infer a latch.
  always_comb begin
    stage_next[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_next[i] = stage_data[i-1];
    end
`ifdef MEM_WRITE_BYPASS_EN
    if (wr) begin
      stage_next[0] = data_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        if (stage_live[i-1] && (stage_idx[i-1] == word_idx)) begin
          stage_next[i] = data_in;
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so that every stage shifts from
  // the pre-edge value of its neighbour, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_data[i] <= stage_next[i];
      end
    end
  end

  assign mem_data_out = stage_data[READ_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Address stability, data_valid and sticky range error
  // ---------------------------------------------------------------------------
  assign addr_changed = (mem_addr[31:2] != prev_word);

  always_comb begin
    cnt_next = stable_cnt;
    if (addr_changed || write_breaks) begin
      cnt_next = '0;
    end else if (stable_cnt != CNT_MAX) begin
      cnt_next = stable_cnt + 3'd1;
    end
  end

  // prev_word also follows the address during reset. A hold that starts in
  // the reset cycle therefore counts up right after reset releases.
  always_ff @(posedge clk) begin
    prev_word <= mem_addr[31:2];
    if (reset) begin
      stable_cnt <= '0;
      data_valid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      stable_cnt <= cnt_next;
      data_valid <= (cnt_next >= VALID_THRESHOLD);
      addr_error <= addr_error | ~in_range;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// -----------------------------------------------------------------------------
// tb_main_memory
//   Self-checking bench for main_memory (ADDR_WIDTH=16, READ_LATENCY=3).
//   Inputs are driven just after the falling edge, and outputs are sampled on
//   the next falling edge. The reference model keeps one record per rising
//   edge: the address seen, the word it sampled, and when the address last
//   broke stability. It derives expected outputs from edge-number arithmetic.
//   Define MEM_WRITE_BYPASS_EN to check the forwarding build.
// -----------------------------------------------------------------------------
module tb_main_memory;

  localparam int AW  = 16;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] data_in;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_out;
  logic            data_valid;
  logic            addr_error;

  main_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .data_in     (data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .data_valid  (data_valid),
    .addr_error  (addr_error)
  );

  always #5 clk = ~clk;

  int cmp_count  = 0;
  int fail_count = 0;

  // Reference model state
  logic [31:0] ref_mem    [int];
  logic [31:0] hist_val   [int];
  bit          hist_known [int];
  bit          hist_inr   [int];
  int          hist_idx   [int];
  int          edge_n     = 0;
  int          last_reset = -100;
  int          last_break = 0;
  logic [29:0] prev_word  = '0;
  bit          ref_err    = 1'b0;
  logic [31:0] exp_out    = '0;
  bit          exp_known  = 1'b0;
  bit          exp_valid  = 1'b0;

  // One clock: drive inputs, advance the model at the rising edge, and return
  // at the falling edge with exp_* describing what the DUT should show.
  task automatic step(input logic [31:0] a, input logic [31:0] d,
                      input bit we, input bit rst);
    int idx;
    bit inr;
    int src;
    reset        = rst;
    mem_addr     = a;
    data_in      = d;
    mem_write_en = we;
    @(posedge clk);
    edge_n++;
    inr = (a[31:AW+2] == '0);
    idx = int'(a[AW+1:2]);
    if (rst) begin
      last_reset = edge_n;
      last_break = edge_n;
      ref_err    = 1'b0;
    end else begin
      hist_inr[edge_n] = inr;
      hist_idx[edge_n] = idx;
      if (!inr) begin
        hist_val[edge_n]   = '0;
        hist_known[edge_n] = 1'b1;
      end else if (ref_mem.exists(idx)) begin
        hist_val[edge_n]   = ref_mem[idx];
        hist_known[edge_n] = 1'b1;
      end else begin
        hist_val[edge_n]   = '0;
        hist_known[edge_n] = 1'b0;
      end
      if (we && inr) ref_mem[idx] = d;
`ifdef MEM_WRITE_BYPASS_EN
      if (a[31:2] != prev_word) last_break = edge_n;
`else
      if ((a[31:2] != prev_word) || we) last_break = edge_n;
`endif
      if (!inr) ref_err = 1'b1;
    end
    prev_word = a[31:2];
    // Output after this edge reflects the address sampled LAT-1 edges ago.
    src = edge_n - LAT + 1;
    if (src <= last_reset) begin
      exp_out   = '0;
      exp_known = 1'b1;
    end else begin
`ifdef MEM_WRITE_BYPASS_EN
      // Forwarding: the word's content as of this edge, including any writes
      // made while the sample was in flight.
      if (!hist_inr[src]) begin
        exp_out   = '0;
        exp_known = 1'b1;
      end else if (ref_mem.exists(hist_idx[src])) begin
        exp_out   = ref_mem[hist_idx[src]];
        exp_known = 1'b1;
      end else begin
        exp_out   = '0;
        exp_known = 1'b0;
      end
`else
      exp_out   = hist_val[src];
      exp_known = hist_known[src];
`endif
    end
    exp_valid = ((edge_n - last_break) >= LAT);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    step(32'h40, 32'h0, 1'b0, 1'b1);
    cmp_count++;
    if (mem_data_out !== 32'h0) begin
      fail_count++;
      $display("FAIL reset_data: got %h want 00000000", mem_data_out);
    end
    cmp_count++;
    if (data_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_valid: got %b want 0", data_valid);
    end
    cmp_count++;
    if (addr_error !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_error: got %b want 0", addr_error);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_read();
    step(32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(32'h40, 32'h0, 1'b0, 1'b0);
      cmp_count++;
      if (data_valid !== exp_valid) begin
        fail_count++;
        $display("FAIL write_read_valid k=%0d: got %b want %b", k, data_valid, exp_valid);
      end
      if (exp_known) begin
        cmp_count++;
        if (mem_data_out !== exp_out) begin
          fail_count++;
          $display("FAIL write_read_data k=%0d: got %h want %h", k, mem_data_out, exp_out);
        end
      end
    end
    cmp_count++;
    if (mem_data_out !== 32'hDEADBEEF || data_valid !== 1'b1) begin
      fail_count++;
      $display("FAIL write_read_3cyc: got %h/%b want deadbeef/1", mem_data_out, data_valid);
    end
    cmp_count++;
    if (mem_data_out[0] !== 8'hDE || mem_data_out[3] !== 8'hEF) begin
      fail_count++;
      $display("FAIL lane_order: got lane0=%h lane3=%h want de/ef",
               mem_data_out[0], mem_data_out[3]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] seq_a [8] = '{32'h100, 32'h104, 32'h100, 32'h104,
                               32'h104, 32'h104, 32'h104, 32'h104};
    logic [31:0] seq_d [8] = '{32'h11223344, 32'h55667788, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 8; k++) begin
      step(seq_a[k], seq_d[k], (k < 2), 1'b0);
      cmp_count++;
      if (data_valid !== exp_valid) begin
        fail_count++;
        $display("FAIL b2b_valid k=%0d: got %b want %b", k, data_valid, exp_valid);
      end
      if (exp_known) begin
        cmp_count++;
        if (mem_data_out !== exp_out) begin
          fail_count++;
          $display("FAIL b2b_data k=%0d: got %h want %h", k, mem_data_out, exp_out);
        end
      end
      // Reads at k=2,3 emerge after k=4,5, and the address settles too late
      // for either of them to be flagged valid.
      if (k == 4 || k == 5) begin
        cmp_count++;
        if (mem_data_out !== ((k == 4) ? 32'h11223344 : 32'h55667788) || data_valid !== 1'b0) begin
          fail_count++;
          $display("FAIL b2b_fill k=%0d: got %h/%b", k, mem_data_out, data_valid);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_read_before_write();
    logic [31:0] want;
    step(32'h200, 32'hAAAAAAAA, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(32'h200, 32'h0, 1'b0, 1'b0);
    step(32'h200, 32'hBBBBBBBB, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(32'h200, 32'h0, 1'b0, 1'b0);
`ifdef MEM_WRITE_BYPASS_EN
      want = 32'hBBBBBBBB;
      cmp_count++;
      if (data_valid !== 1'b1) begin
        fail_count++;
        $display("FAIL rbw_bypass_valid k=%0d: got %b want 1", k, data_valid);
      end
`else
      want = (k <= 2) ? 32'hAAAAAAAA : 32'hBBBBBBBB;
      cmp_count++;
      if (data_valid !== exp_valid) begin
        fail_count++;
        $display("FAIL rbw_valid k=%0d: got %b want %b", k, data_valid, exp_valid);
      end
`endif
      cmp_count++;
      if (mem_data_out !== want) begin
        fail_count++;
        $display("FAIL rbw_data k=%0d: got %h want %h", k, mem_data_out, want);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_out_of_range();
    step(32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0004_0000, 32'h12345678, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(32'h0004_0000, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (mem_data_out !== 32'h0 || addr_error !== 1'b1) begin
      fail_count++;
      $display("FAIL oor_read: got %h/%b want 00000000/1", mem_data_out, addr_error);
    end
    for (int k = 0; k < 3; k++) begin
      step(32'h0, 32'h0, 1'b0, 1'b0);
      cmp_count++;
      if (addr_error !== 1'b1) begin
        fail_count++;
        $display("FAIL oor_sticky k=%0d: got %b want 1", k, addr_error);
      end
    end
    cmp_count++;
    if (mem_data_out !== 32'hCAFEF00D) begin
      fail_count++;
      $display("FAIL oor_no_alias: got %h want cafef00d", mem_data_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    step(32'h40, 32'h0, 1'b0, 1'b0);
    step(32'h40, 32'h0, 1'b0, 1'b1);
    cmp_count++;
    if (mem_data_out !== 32'h0 || data_valid !== 1'b0 || addr_error !== 1'b0) begin
      fail_count++;
      $display("FAIL mid_read_reset: got %h/%b/%b want 00000000/0/0",
               mem_data_out, data_valid, addr_error);
    end
    for (int k = 0; k < 3; k++) step(32'h40, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (mem_data_out !== 32'hDEADBEEF || data_valid !== 1'b1) begin
      fail_count++;
      $display("FAIL mid_read_retain: got %h/%b want deadbeef/1", mem_data_out, data_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cache_pattern();
    step(32'h300, 32'h0, 1'b0, 1'b0);
    step(32'h300, 32'h9ABCDEF0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(32'h40, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (mem_data_out !== 32'hDEADBEEF || data_valid !== 1'b1) begin
      fail_count++;
      $display("FAIL cache_fill: got %h/%b want deadbeef/1", mem_data_out, data_valid);
    end
    for (int k = 0; k < 4; k++) step(32'h300, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (mem_data_out !== 32'h9ABCDEF0 || data_valid !== 1'b1) begin
      fail_count++;
      $display("FAIL cache_writeback: got %h/%b want 9abcdef0/1", mem_data_out, data_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [31:0] pool [8] = '{32'h0, 32'h8, 32'h40, 32'h100,
                              32'h104, 32'h200, 32'h300, 32'hFFFC};
    logic [31:0] a;
    bit          we;
    bit          rst;
    a = pool[0];
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 40) a = pool[$urandom_range(0, 7)];
      // Bits [1:0] must be ignored by both the read and the stability tracking.
      a[1:0] = 2'($urandom_range(0, 3));
      we  = ($urandom_range(0, 99) < 25);
      rst = ($urandom_range(0, 99) < 3);
      step(a, $urandom, we, rst);
      cmp_count++;
      if (data_valid !== exp_valid) begin
        fail_count++;
        $display("FAIL rand_valid edge=%0d: got %b want %b", edge_n, data_valid, exp_valid);
      end
      cmp_count++;
      if (addr_error !== ref_err) begin
        fail_count++;
        $display("FAIL rand_error edge=%0d: got %b want %b", edge_n, addr_error, ref_err);
      end
      if (exp_known) begin
        cmp_count++;
        if (mem_data_out !== exp_out) begin
          fail_count++;
          $display("FAIL rand_data edge=%0d: got %h want %h", edge_n, mem_data_out, exp_out);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    mem_addr     = '0;
    data_in      = '0;
    mem_write_en = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_before_write();
    test_out_of_range();
    test_reset_mid_read();
    test_cache_pattern();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
